// File: rtl/booth_ctrl.sv
// rtl/booth_ctrl.sv - radix-2 Booth multiplier control sequencer (CLR, LOAD, WIDTH x RUN, DONE)
// Optional abort path enabled by defining BOOTH_ABORT_EN.
module booth_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] q_q_1,
`ifdef BOOTH_ABORT_EN
  input  logic       abort,
`endif
  output logic       load_M,
  output logic       dp_clr,
  output logic       load_A,
  output logic       load_Q,
  output logic       en,
  output logic [1:0] alu_op,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_ZERO = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_hit;

`ifdef BOOTH_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_M  = 1'b0;
    dp_clr  = 1'b0;
    load_A  = 1'b0;
    load_Q  = 1'b0;
    en      = 1'b0;
    alu_op  = OP_PASS;
    busy    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLR;
      end
      S_CLR: begin
        dp_clr  = 1'b1;
        load_M  = 1'b1;
        busy    = 1'b1;
        state_d = abort_hit ? S_IDLE : S_LOAD;
      end
      S_LOAD: begin
        en      = 1'b1;
        load_Q  = 1'b1;
        load_A  = 1'b1;
        alu_op  = OP_ZERO;
        busy    = 1'b1;
        cnt_d   = '0;
        state_d = abort_hit ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        en    = 1'b1;
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        // {Q0,Q-1}: 01 ends a run of ones (add), 10 starts one (subtract)
        unique case (q_q_1)
          2'b01: begin
            load_A = 1'b1;
            alu_op = OP_ADD;
          end
          2'b10: begin
            load_A = 1'b1;
            alu_op = OP_SUB;
          end
          default: begin
            load_A = 1'b0;
            alu_op = OP_PASS;
          end
        endcase
        if (abort_hit)              state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        busy    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_booth_ctrl.sv
// tb/tb_booth_ctrl.sv - directed bench for booth_ctrl driving a behavioural Booth datapath
module tb_booth_ctrl;

  localparam int WIDTH = 16;

  logic        clk_in = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  q_q_1;
`ifdef BOOTH_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic        load_M, dp_clr, load_A, load_Q, en, busy, done;
  logic [1:0]  alu_op;

  booth_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .start  (start),
    .q_q_1  (q_q_1),
`ifdef BOOTH_ABORT_EN
    .abort  (abort),
`endif
    .load_M (load_M),
    .dp_clr (dp_clr),
    .load_A (load_A),
    .load_Q (load_Q),
    .en     (en),
    .alu_op (alu_op),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural datapath: A/Q/Q-1 shift register and ALU with a sign-extended sum
  logic [15:0]        mcand = '0, mult = '0;
  logic [15:0]        dp_a = '0, dp_q = '0, dp_m = '0;
  logic               dp_q1 = 1'b0;
  logic signed [16:0] alu_out, shift_src;

  assign q_q_1 = {dp_q[0], dp_q1};

  always_comb begin
    alu_out = '0;
    case (alu_op)
      2'b00: alu_out = {dp_a[15], dp_a};
      2'b01: alu_out = {dp_a[15], dp_a} + {dp_m[15], dp_m};
      2'b10: alu_out = {dp_a[15], dp_a} - {dp_m[15], dp_m};
      default: alu_out = '0;
    endcase
    shift_src = load_A ? alu_out : {dp_a[15], dp_a};
  end

  always @(posedge clk_in) begin
    if (dp_clr) begin
      dp_a  <= '0;
      dp_q  <= '0;
      dp_q1 <= 1'b0;
    end
    if (load_M) dp_m <= mcand;
    if (en) begin
      if (load_Q) begin
        dp_q <= mult;
        dp_a <= alu_out[15:0];
      end else begin
        dp_a  <= shift_src[16:1];
        dp_q  <= {shift_src[0], dp_q[15:1]};
        dp_q1 <= dp_q[0];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  logic [8:0] outs;
  assign outs = {load_M, dp_clr, load_A, load_Q, en, alu_op, busy, done};

  int         done_cnt, done_first, busy_cnt, overlap_cnt;
  logic [1:0] run_alu [WIDTH];
  logic       run_la  [WIDTH];

  // ev_kind: 0 none, 1 extra start, 2 reset pulse, 3 abort; ev_k is the sample index
  task automatic run_op(input logic [15:0] m, input logic [15:0] q, input int ev_k, input int ev_kind);
    mcand      = m;
    mult       = q;
    done_cnt   = 0;
    done_first = 0;
    busy_cnt   = 0;
    @(negedge clk_in);
    start = 1'b1;
    @(posedge clk_in);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk_in);
      start = 1'b0;
`ifdef BOOTH_ABORT_EN
      abort = 1'b0;
`endif
      if (ev_kind == 2 && k == ev_k + 2) rst = 1'b1;
      if (done) begin
        done_cnt++;
        if (done_first == 0) done_first = k;
      end
      if (busy) busy_cnt++;
      if (dp_clr && load_Q) overlap_cnt++;
      if (k >= 3 && k < 3 + WIDTH) begin
        run_alu[k-3] = alu_op;
        run_la[k-3]  = load_A;
      end
      if (ev_kind == 3 && k == ev_k + 1) begin
        check_eq("abort_en_low", {31'd0, en}, 32'd0);
        check_eq("abort_idle", {31'd0, busy}, 32'd0);
      end
      if (k == ev_k) begin
        case (ev_kind)
          1: start = 1'b1;
          2: begin
            rst = 1'b0;
            #1;
            check_eq("midrun_reset_outs", {23'd0, outs}, 32'd0);
          end
`ifdef BOOTH_ABORT_EN
          3: abort = 1'b1;
`endif
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    overlap_cnt = 0;
    repeat (3) @(negedge clk_in);
    check_eq("reset_outs", {23'd0, outs}, 32'd0);
    rst = 1'b1;
    @(negedge clk_in);
    check_eq("idle_outs", {23'd0, outs}, 32'd0);

    run_op(16'd3, 16'd5, 0, 0);
    check_eq("p3x5_done_lat", done_first, 32'd19);
    check_eq("p3x5_done_cnt", done_cnt, 32'd1);
    check_eq("p3x5_busy_cycles", busy_cnt, 32'd19);
    check_eq("p3x5_product", {dp_a, dp_q}, 32'h0000000F);

    run_op(16'hFFFD, 16'd7, 0, 0);
    check_eq("pm3x7_product", {dp_a, dp_q}, 32'hFFFFFFEB);
    check_eq("pm3x7_run0_op", {30'd0, run_alu[0]}, 32'd2);
    check_eq("pm3x7_run0_loadA", {31'd0, run_la[0]}, 32'd1);

    run_op(16'h8000, 16'h8000, 0, 0);
    check_eq("p8000_product", {dp_a, dp_q}, 32'h40000000);
    begin
      int nz = 0;
      for (int i = 0; i < WIDTH - 1; i++) if (run_alu[i] != 2'b00) nz++;
      check_eq("p8000_shift_only", nz, 32'd0);
    end
    check_eq("p8000_run15_op", {30'd0, run_alu[WIDTH-1]}, 32'd2);

    run_op(16'd3, 16'd5, 7, 1);
    check_eq("restart_done_cnt", done_cnt, 32'd1);
    check_eq("restart_done_lat", done_first, 32'd19);
    check_eq("restart_product", {dp_a, dp_q}, 32'h0000000F);

    run_op(16'd3, 16'd5, 10, 2);
    check_eq("reset_no_done", done_cnt, 32'd0);
    run_op(16'd2, 16'hFFFC, 0, 0);
    check_eq("p2xm4_product", {dp_a, dp_q}, 32'hFFFFFFF8);
    check_eq("p2xm4_done_lat", done_first, 32'd19);

`ifdef BOOTH_ABORT_EN
    run_op(16'd3, 16'd5, 6, 3);
    check_eq("abort_no_done", done_cnt, 32'd0);
    run_op(16'd6, 16'd6, 0, 0);
    check_eq("p6x6_product", {dp_a, dp_q}, 32'h00000024);
    check_eq("p6x6_done_cnt", done_cnt, 32'd1);
`endif

    check_eq("clr_loadq_overlap", overlap_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_ctrl.md
Name: booth_ctrl

Overview:
- Control sequencer for the radix-2 Booth multiplier datapath. It drives the combined A/Q/Q-1 shift register and the add/sub ALU.
- It accepts a start request, clears and loads the datapath, then runs WIDTH add/sub-and-shift iterations by decoding the {Q0,Q-1} pair fed back from the register. It then signals completion.
- It is the consumer of the Q_Q_1 output and the producer of the load_A, load_Q and en inputs of the shift register.

Parameters:
- WIDTH, 16, operand width; number of Booth iterations.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_in  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-low reset for all controller state.
- start  input  1  request pulse; sampled only in IDLE.
- q_q_1  input  2  {Q0, Q-1} from the shift register; bit1 = Q0, bit0 = Q-1.
- load_M  output  1  latch the multiplicand into the ALU M operand.
- dp_clr  output  1  one-cycle clear of the datapath registers (forces Q-1 = 0).
- load_A  output  1  A <= arithmetic-shift of alu_out, Q15 <= alu_out[0]; when 0, A shifts right arithmetically.
- load_Q  output  1  parallel-load the multiplier into Q.
- en  output  1  datapath clock enable.
- alu_op  output  2  00 PASS(A), 01 ADD(A+M), 10 SUB(A-M), 11 ZERO.
- busy  output  1  high from the cycle after start is accepted until DONE completes.
- done  output  1  one-cycle pulse; the product on the datapath out is valid and held.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0. All outputs 0, alu_op=00.
- State IDLE: all outputs 0, en=0, so the datapath holds the last product. If start=1, the next state is CLR.
- State CLR: dp_clr=1, load_M=1, en=0, busy=1. The next state is LOAD.
- State LOAD: en=1, load_Q=1, load_A=1, alu_op=11 (ZERO), busy=1, counter<=0. The result is A=0, Q=multiplier, Q-1=0. The next state is RUN.
- State RUN: en=1, busy=1. Outputs decode combinationally (Mealy) from q_q_1:
  - 01 -> load_A=1, alu_op=01.
  - 10 -> load_A=1, alu_op=10.
  - 00 or 11 -> load_A=0, alu_op=00 (pure shift).
  - The counter increments each RUN cycle. When counter==WIDTH-1, the next state is DONE; otherwise stay in RUN.
- State DONE: en=0, done=1, busy=1. The next state is IDLE.
- Latency: start sampled high at edge N gives CLR at N+1, LOAD at N+2, RUN at N+3..N+2+WIDTH, and DONE at N+3+WIDTH. For WIDTH=16, done is seen 19 cycles after the start edge.
- start while not IDLE: ignored, with no queueing. start held high in IDLE after DONE begins a new operation.
- load_Q is high only in LOAD. dp_clr is high only in CLR. Never assert load_Q and dp_clr in the same cycle.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No done pulse is produced.
- The counter width covers WIDTH-1 without wrap. The counter is not used outside RUN.

Optional Feature:
- Macro: BOOTH_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort=1 in CLR, LOAD or RUN gives next state IDLE, with en=0 from that next cycle and no done pulse.
  - abort in IDLE or DONE has no effect. DONE still pulses.
  - abort and start both high in IDLE: start wins.
- When undefined: the port is absent and there is no abort path.

Test Plan:
- M=3, Q=5, single start pulse: done exactly 19 cycles after the start edge; datapath out=0x0000000F; busy high for 19 cycles.
- M=-3 (0xFFFD), Q=7: out=0xFFFFFFEB. The first RUN cycle shows alu_op=10 and load_A=1 (q_q_1=10).
- M=0x8000, Q=0x8000: out=0x40000000. The RUN cycles show alu_op=00 for the first 15 iterations, then alu_op=10 on the 16th.
- start pulsed again at cycle 5 of RUN: ignored; the single done and the product are unchanged.
- rst driven low at the 8th RUN cycle, then released and start issued with M=2, Q=-4: outputs 0 during reset, no done; the next operation gives out=0xFFFFFFF8.
- With BOOTH_ABORT_EN: abort at the 4th RUN cycle -> IDLE next cycle, en=0, no done. A following start with M=6, Q=6 gives out=0x00000024.
